// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO: pointer sizing and full/empty pointer compares.
// Pointers are passed zero-extended to 32 bits so one set of helpers serves every AW.
package fifo_pkg;

    function automatic int unsigned ptr_width(input int unsigned aw);
        return aw + 1;
    endfunction

    // Equal pointers, including the wrap bit, mean nothing is stored.
    function automatic logic ptrs_empty(input logic [31:0] wp, input logic [31:0] rp);
        return wp == rp;
    endfunction

    // Full when only the wrap bit (bit aw) differs between the two pointers.
    function automatic logic ptrs_full(input logic [31:0] wp, input logic [31:0] rp,
                                       input int unsigned aw);
        return (wp ^ rp) == (32'd1 << aw);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DW x 2**AW storage for sync_fifo: one synchronous write port, one asynchronous read port.
// Kept separate so a vendor RAM can be dropped in without touching the control logic.
module sync_fifo_ram #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count and threshold status flags.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DW        = 8,
    parameter int unsigned AW        = 4,
    parameter int unsigned AFULL_TH  = 14,
    parameter int unsigned AEMPTY_TH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] wdata,
    input  logic          winc,
    output logic          wfull,
    output logic          walmost_full,
    input  logic          rinc,
    output logic [DW-1:0] rdata,
    output logic          rempty,
    output logic          ralmost_empty,
    output logic [AW:0]   count
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic          overflow,
    output logic          underflow
`endif
);

    localparam int unsigned PW = ptr_width(AW);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [AW:0]   count_t;

    localparam count_t FullCnt   = count_t'(2**AW);
    localparam count_t AfullCnt  = count_t'(AFULL_TH);
    localparam count_t AemptyCnt = count_t'(AEMPTY_TH);

    initial begin
        assert (AW >= 1 && AEMPTY_TH < AFULL_TH && AFULL_TH <= 2**AW)
        else $fatal(1, "sync_fifo: illegal AW/AFULL_TH/AEMPTY_TH combination");
    end

    ptr_t   wptr_q, wptr_d, rptr_q, rptr_d;
    count_t count_q, count_d;
    logic   wr_acc, rd_acc;

    // Flags depend on registered state only, so no input reaches an output combinationally.
    assign rempty        = (count_q == '0);
    assign wfull         = (count_q == FullCnt);
    assign walmost_full  = (count_q >= AfullCnt);
    assign ralmost_empty = (count_q <= AemptyCnt);
    assign count         = count_q;

    assign wr_acc = winc && !wfull;
    assign rd_acc = rinc && !rempty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_acc) wptr_d = wptr_q + ptr_t'(1);
        if (rd_acc) rptr_d = rptr_q + ptr_t'(1);
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + count_t'(1);
            2'b01:   count_d = count_q - count_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // A write requested in the reset cycle must not land in memory.
    sync_fifo_ram #(
        .DW(DW),
        .AW(AW)
    ) u_ram (
        .clk  (clk),
        .we   (wr_acc && !rst),
        .waddr(wptr_q[AW-1:0]),
        .wdata(wdata),
        .raddr(rptr_q[AW-1:0]),
        .rdata(rdata)
    );

    // The pointer view of full/empty must always match the occupancy counter.
    assert property (@(posedge clk) disable iff (rst)
        (ptrs_empty(32'(wptr_q), 32'(rptr_q)) == rempty) &&
        (ptrs_full(32'(wptr_q), 32'(rptr_q), AW) == wfull));

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (winc && wfull)  overflow_q  <= 1'b1;
            if (rinc && rempty) underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DW=8, AW=4, AFULL_TH=14, AEMPTY_TH=2).
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wdata;
    logic       winc, rinc;
    logic       wfull, walmost_full, rempty, ralmost_empty;
    logic [7:0] rdata;
    logic [4:0] count;
`ifdef SYNC_FIFO_ERR_EN
    logic       overflow, underflow;
`endif

    int vectors    = 0;
    int miscompares = 0;

    sync_fifo #(
        .DW(8),
        .AW(4),
        .AFULL_TH(14),
        .AEMPTY_TH(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wdata        (wdata),
        .winc         (winc),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .rinc         (rinc),
        .rdata        (rdata),
        .rempty       (rempty),
        .ralmost_empty(ralmost_empty),
        .count        (count)
`ifdef SYNC_FIFO_ERR_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag, input int cnt);
        chk({tag, ".count"}, 32'(count), 32'(cnt));
        chk({tag, ".rempty"}, 32'(rempty), 32'(cnt == 0));
        chk({tag, ".wfull"}, 32'(wfull), 32'(cnt == 16));
        chk({tag, ".walmost_full"}, 32'(walmost_full), 32'(cnt >= 14));
        chk({tag, ".ralmost_empty"}, 32'(ralmost_empty), 32'(cnt <= 2));
    endtask

    initial begin
        rst   = 1'b1;
        winc  = 1'b0;
        rinc  = 1'b0;
        wdata = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_status("reset_idle", 0);

        // Fill with 0x01..0x10; walmost_full rises at 14, wfull at 16.
        for (int i = 1; i <= 16; i++) begin
            winc  = 1'b1;
            wdata = 8'(i);
            tick();
            chk_status("fill", i);
            chk("fill.head", 32'(rdata), 32'h01);
        end
        winc = 1'b0;

        // Plain write while full is dropped.
        winc  = 1'b1;
        wdata = 8'hEE;
        tick();
        winc = 1'b0;
        chk_status("write_at_full", 16);
        chk("write_at_full.head", 32'(rdata), 32'h01);

        // Drain in order.
        for (int i = 1; i <= 16; i++) begin
            chk("drain.data", 32'(rdata), 32'(i));
            rinc = 1'b1;
            tick();
            chk_status("drain", 16 - i);
        end
        rinc = 1'b0;

        // Read while empty is ignored.
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        chk_status("read_at_empty", 0);

        // Refill with 0x21..0x30, then simultaneous ops at full and at 15.
        for (int i = 0; i < 16; i++) begin
            winc  = 1'b1;
            wdata = 8'(8'h21 + i);
            tick();
        end
        chk_status("refill", 16);
        wdata = 8'hAA;
        rinc  = 1'b1;
        tick();
        chk_status("rw_at_full", 15);
        wdata = 8'hBB;
        tick();
        chk_status("rw_at_15", 15);
        winc = 1'b0;
        rinc = 1'b0;
        // 0x21 and 0x22 popped; 0xAA dropped; 0xBB is the tail.
        for (int i = 0; i < 15; i++) begin
            chk("rw_drain.data", 32'(rdata), (i == 14) ? 32'hBB : 32'(8'h23 + i));
            rinc = 1'b1;
            tick();
        end
        rinc = 1'b0;
        chk_status("rw_drained", 0);

        // Sustained read+write at count 8 across pointer wrap.
        for (int i = 0; i < 8; i++) begin
            winc  = 1'b1;
            wdata = 8'(8'h40 + i);
            tick();
        end
        rinc = 1'b1;
        for (int k = 0; k < 40; k++) begin
            wdata = 8'(8'h48 + k);
            chk("wrap.data", 32'(rdata), 32'(8'h40 + k));
            tick();
            chk("wrap.count", 32'(count), 32'd8);
            chk("wrap.wfull", 32'(wfull), 32'd0);
            chk("wrap.rempty", 32'(rempty), 32'd0);
        end
        rinc = 1'b0;
        chk("wrap.tail_head", 32'(rdata), 32'h68);

        // Reset at count 9 with a write in flight.
        wdata = 8'h99;
        tick();
        winc = 1'b0;
        chk_status("pre_reset", 9);
        rst   = 1'b1;
        winc  = 1'b1;
        rinc  = 1'b1;
        wdata = 8'h77;
        tick();
        rst  = 1'b0;
        winc = 1'b0;
        rinc = 1'b0;
        chk_status("mid_reset", 0);

        // First write after reset shows ahead next cycle.
        winc  = 1'b1;
        wdata = 8'h55;
        tick();
        winc = 1'b0;
        chk_status("post_reset_write", 1);
        chk("post_reset_write.data", 32'(rdata), 32'h55);
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        chk_status("post_reset_read", 0);

`ifdef SYNC_FIFO_ERR_EN
        chk("err.init_over", 32'(overflow), 32'd0);
        chk("err.init_under", 32'(underflow), 32'd0);
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        chk("err.under_set", 32'(underflow), 32'd1);
        chk_status("err.under_nostate", 0);
        for (int i = 0; i < 16; i++) begin
            winc  = 1'b1;
            wdata = 8'(i);
            tick();
        end
        chk("err.under_sticky", 32'(underflow), 32'd1);
        chk("err.over_clear", 32'(overflow), 32'd0);
        tick();
        winc = 1'b0;
        chk("err.over_set", 32'(overflow), 32'd1);
        chk_status("err.over_nostate", 16);
        tick();
        chk("err.over_sticky", 32'(overflow), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("err.rst_over", 32'(overflow), 32'd0);
        chk("err.rst_under", 32'(underflow), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock, parametrised synchronous FIFO, successor to the async FIFO storage block.
- Integrates storage, read/write pointers, occupancy counter, and full/empty/almost-full/almost-empty status.
- Used for same-clock-domain buffering between pipeline stages where no CDC is needed.
- Show-ahead read: head word is always visible on rdata while not empty.

Parameters:
DW, 8, data width in bits
AW, 4, address width; depth DP = 2**AW
AFULL_TH, 14, walmost_full asserts when count >= AFULL_TH; legal range AEMPTY_TH < AFULL_TH <= DP
AEMPTY_TH, 2, ralmost_empty asserts when count <= AEMPTY_TH; legal range 0 <= AEMPTY_TH < AFULL_TH

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  synchronous active-high reset
wdata  in  DW  write data
winc  in  1  write request
wfull  out  1  FIFO full
walmost_full  out  1  count >= AFULL_TH
rinc  in  1  read request; pops the head word
rdata  out  DW  head-of-FIFO data (show-ahead)
rempty  out  1  FIFO empty
ralmost_empty  out  1  count <= AEMPTY_TH
count  out  AW+1  current occupancy, 0..DP

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset state:
  - wptr = rptr = 0, count = 0.
  - rempty = 1, ralmost_empty = 1, wfull = 0, walmost_full = 0.
  - Memory contents are not reset.
- Pointers:
  - wptr and rptr are AW+1 bits; the low AW bits address memory and the MSB is the wrap bit.
  - Each pointer increments by 1 on an accepted operation and wraps naturally (2*DP → 0).
- Accept rules:
  - Write accepted iff winc && !wfull: mem[wptr[AW-1:0]] <= wdata, then wptr++.
  - Read accepted iff rinc && !rempty: rptr++.
- Simultaneous operations:
  - Both accepted in the same cycle: count unchanged, both pointers advance.
  - When full, rinc && winc: only the read is accepted and count drops by 1. The write is dropped; no write-through.
  - When empty, rinc && winc: only the write is accepted and count rises by 1.
- Status flags:
  - All flags are combinational from registered state only, with no input-to-output paths.
  - rempty = (count == 0); wfull = (count == DP).
  - Full occurs when the pointer MSBs differ and the low bits are equal; empty when the pointers are equal. These must agree with count.
- Read data:
  - rdata = mem[rptr[AW-1:0]], asynchronous read.
  - A write to an empty FIFO is visible on rdata the cycle after the write edge.
  - rdata is don't-care while rempty = 1.
- Latency: write-to-rempty deassert is 1 cycle. Read-to-wfull deassert is 1 cycle.
- Reset mid-operation: all state returns to reset values on the next edge, and in-flight winc/rinc in that cycle are ignored.
- Illegal parameters (threshold ordering violated, AW < 1) must fail elaboration via an initial assertion.

Optional Feature:
SYNC_FIFO_ERR_EN
- Defined:
  - Adds sticky outputs overflow (winc && wfull) and underflow (rinc && rempty), each 1 bit.
  - Each flag is set on the offending edge and cleared only by rst.
  - The rejected operation still has no effect on state.
- Undefined: the overflow/underflow ports and logic are absent; rejected operations are silently dropped.

Decomposition:
- Package fifo_pkg:
  - Function for pointer width (AW+1).
  - Parametrised typedefs for pointer and count.
  - Full/empty compare helper functions.
- Sub-module sync_fifo_ram:
  - DW x DP array, one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
  - Gives vendor-RAM substitution a single swap point.

Test Plan:
- Reset then idle → count=0, rempty=1, ralmost_empty=1, wfull=0, walmost_full=0.
- Write 0x01..0x10 on 16 consecutive cycles (DW=8, AW=4) → walmost_full rises after the 14th write, wfull=1 and count=16 after the 16th; then read 16 → data 0x01..0x10 in order, rempty=1.
- Fill to 16, then assert winc+rinc with wdata=0xAA → read accepted, 0xAA dropped, count=15. Then winc+rinc at count=15 with wdata=0xBB → count stays 15, 0xBB appears as the last word read out.
- Wrap-around: 40 cycles of sustained winc+rinc at count=8 → data order preserved, pointers wrap past 2*DP with no spurious full/empty.
- Assert rst with count=9 and winc=1 → next cycle count=0, rempty=1, and the write is not stored.
- With SYNC_FIFO_ERR_EN defined: rinc while empty → underflow=1 and stays set. winc at full → overflow=1. Both clear only on rst.
